// File: rtl/aes_pkg.sv
// Shared constants, state encoding and FIPS-197 vectors for the AES-128 controller.
package aes_pkg;

  localparam int BLK_W           = 128;
  localparam int LATENCY_DEF     = 10;
  localparam int KEY_LATENCY_DEF = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    KEY_WAIT = 2'd1,
    RUN      = 2'd2,
    DRAIN    = 2'd3
  } aes_state_e;

  localparam logic [127:0] FIPS_V1_KEY =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_V1_PT =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_V1_CT =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_B_KEY =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_B_PT =
    128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_B_CT =
    128'h3925841d02dc09fbdc118597196a0b32;

endpackage

// File: rtl/aes_ctrl_fifo.sv
// First-word-fall-through FIFO with occupancy count.
// Push into a full FIFO is allowed only together with a pop.
module aes_ctrl_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_Push,
  input  logic [WIDTH-1:0]         i_Data,
  input  logic                     i_Pop,
  output logic [WIDTH-1:0]         o_Data,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign o_Empty = (r_cnt == '0);
  assign w_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = i_Pop && !o_Empty;
  assign w_push  = i_Push && (!w_full || w_pop);
  assign o_Data  = r_mem[r_rd];
  assign o_Count = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_Data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(i_Push && w_full && !w_pop)
  );

endmodule

// File: rtl/aes_encrypt_ctrl.sv
// Handshake, credit and key-sequencing front end for the AES-128 pipeline.
// Define AES_CTRL_TAG_EN to carry a user tag alongside each block.
module aes_encrypt_ctrl
  import aes_pkg::*;
#(
  parameter int LATENCY     = LATENCY_DEF,
  parameter int KEY_LATENCY = KEY_LATENCY_DEF,
  parameter int FIFO_DEPTH  = 16,
  parameter int TAG_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_Valid,
  output logic               o_Ready,
  input  logic [BLK_W-1:0]   i_Key,
  input  logic [BLK_W-1:0]   i_Plain_Text,
`ifdef AES_CTRL_TAG_EN
  input  logic [TAG_W-1:0]   i_Tag,
`endif
  output logic [BLK_W-1:0]   o_Pipe_Key,
  output logic [BLK_W-1:0]   o_Pipe_Plain_Text,
  input  logic [BLK_W-1:0]   i_Pipe_Cipher_Text,
  output logic               o_Valid,
  input  logic               i_Ready,
  output logic [BLK_W-1:0]   o_Cipher_Text,
`ifdef AES_CTRL_TAG_EN
  output logic [TAG_W-1:0]   o_Tag,
`endif
  output logic               o_Busy
);

`ifdef AES_CTRL_TAG_EN
  localparam int TW = TAG_W;
`else
  localparam int TW = 0 * TAG_W;
`endif
  localparam int DW = BLK_W + TW;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int KW = $clog2(KEY_LATENCY + 1);
  localparam int IW = $clog2(LATENCY + 1);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_KEY_WAIT = KEY_WAIT;
  localparam logic [1:0] S_RUN      = RUN;
  localparam logic [1:0] S_DRAIN    = DRAIN;

  logic [1:0]         r_state;
  logic [BLK_W-1:0]   r_key;
  logic [KW-1:0]      r_key_cnt;
  logic [LATENCY-1:0] r_vld;
  logic [IW-1:0]      r_inflight;
  logic [CW-1:0]      w_fifo_cnt;
  logic               w_fifo_empty;
  logic [DW-1:0]      w_fifo_d;
  logic [DW-1:0]      w_fifo_q;
  logic               w_key_match;
  logic               w_credit;
  logic               w_accept;
  logic               w_out_vld;

  assign w_key_match = (i_Key == r_key);
  assign w_credit    = (int'(r_inflight) + int'(w_fifo_cnt)) < FIFO_DEPTH;
  assign o_Ready     = (r_state == S_RUN) && w_key_match && w_credit;
  assign w_accept    = i_Valid && o_Ready;
  assign w_out_vld   = r_vld[LATENCY-1];

  assign o_Pipe_Key        = r_key;
  assign o_Pipe_Plain_Text = i_Plain_Text;
  assign o_Valid           = !w_fifo_empty;
  assign o_Cipher_Text     = w_fifo_q[BLK_W-1:0];
  assign o_Busy = (r_state != S_IDLE) || (r_inflight != '0) || !w_fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_key      <= '0;
      r_key_cnt  <= '0;
      r_vld      <= '0;
      r_inflight <= '0;
    end else begin
      r_vld      <= {r_vld[LATENCY-2:0], w_accept};
      r_inflight <= r_inflight + IW'(w_accept) - IW'(w_out_vld);
      unique case (r_state)
        S_IDLE: begin
          if (i_Valid) begin
            r_key     <= i_Key;
            r_key_cnt <= KW'(KEY_LATENCY - 1);
            r_state   <= S_KEY_WAIT;
          end
        end
        S_KEY_WAIT: begin
          if (r_key_cnt == '0) r_state <= S_RUN;
          else r_key_cnt <= r_key_cnt - 1'b1;
        end
        S_RUN: begin
          if (i_Valid && !w_key_match) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Key may only change once the last old-key block has left the pipe
          if (r_inflight == '0) begin
            r_key     <= i_Key;
            r_key_cnt <= KW'(KEY_LATENCY - 1);
            r_state   <= S_KEY_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef AES_CTRL_TAG_EN
  logic [TAG_W-1:0] r_tag [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= i_Tag;
      for (int i = 1; i < LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_fifo_d = {r_tag[LATENCY-1], i_Pipe_Cipher_Text};
  assign o_Tag    = w_fifo_q[DW-1:BLK_W];
`else
  assign w_fifo_d = i_Pipe_Cipher_Text;
`endif

  aes_ctrl_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_Push  (w_out_vld),
    .i_Data  (w_fifo_d),
    .i_Pop   (i_Ready),
    .o_Data  (w_fifo_q),
    .o_Empty (w_fifo_empty),
    .o_Count (w_fifo_cnt)
  );

endmodule

// File: tb/tb_aes_encrypt_ctrl.sv
// Bench for aes_encrypt_ctrl with a behavioural 10-stage datapath and a
// result scoreboard; the tag test is built when AES_CTRL_TAG_EN is defined.
module tb_aes_encrypt_ctrl;
  import aes_pkg::*;

  localparam int LAT   = 10;
  localparam int KLAT  = 10;
  localparam int DEPTH = 16;
  localparam int TW    = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_Valid = 1'b0;
  logic         o_Ready;
  logic [127:0] i_Key = '0;
  logic [127:0] i_Plain_Text = '0;
  logic [127:0] o_Pipe_Key;
  logic [127:0] o_Pipe_Plain_Text;
  logic [127:0] i_Pipe_Cipher_Text;
  logic         o_Valid;
  logic         i_Ready = 1'b1;
  logic [127:0] o_Cipher_Text;
  logic         o_Busy;
`ifdef AES_CTRL_TAG_EN
  logic [TW-1:0] i_Tag = '0;
  logic [TW-1:0] o_Tag;
  logic [TW-1:0] q_tag [$];
  logic [TW-1:0] m_tag;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [127:0] q_ct [$];
  logic [127:0] out_log [$];
  logic [127:0] m_exp;
  logic [127:0] pipe [LAT];

  always #5 clk = ~clk;

  aes_encrypt_ctrl #(
    .LATENCY     (LAT),
    .KEY_LATENCY (KLAT),
    .FIFO_DEPTH  (DEPTH),
    .TAG_W       (TW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_Valid            (i_Valid),
    .o_Ready            (o_Ready),
    .i_Key              (i_Key),
    .i_Plain_Text       (i_Plain_Text),
`ifdef AES_CTRL_TAG_EN
    .i_Tag              (i_Tag),
`endif
    .o_Pipe_Key         (o_Pipe_Key),
    .o_Pipe_Plain_Text  (o_Pipe_Plain_Text),
    .i_Pipe_Cipher_Text (i_Pipe_Cipher_Text),
    .o_Valid            (o_Valid),
    .i_Ready            (i_Ready),
    .o_Cipher_Text      (o_Cipher_Text),
`ifdef AES_CTRL_TAG_EN
    .o_Tag              (o_Tag),
`endif
    .o_Busy             (o_Busy)
  );

  function automatic logic [127:0] model(input logic [127:0] k,
                                         input logic [127:0] p);
    if (k == FIPS_V1_KEY && p == FIPS_V1_PT) return FIPS_V1_CT;
    if (k == FIPS_B_KEY && p == FIPS_B_PT) return FIPS_B_CT;
    return p ^ {k[63:0], k[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  function automatic logic [127:0] mkpt(input int i);
    return {32'hc0de0000, 32'(i), 32'h5a5a0000, 32'(i * 7)};
  endfunction

  // Behavioural datapath: result leaves stage LAT-1 LAT-1 edges after capture
  always @(posedge clk) begin
    pipe[0] <= model(o_Pipe_Key, o_Pipe_Plain_Text);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign i_Pipe_Cipher_Text = pipe[LAT-1];

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_Valid && i_Ready) begin
        n_chk++;
        if (q_ct.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got ct %h, required no output", o_Cipher_Text);
        end else begin
          m_exp = q_ct.pop_front();
          if (o_Cipher_Text !== m_exp) begin
            n_fail++;
            $display("FAIL sb_ct: got %h, required %h", o_Cipher_Text, m_exp);
          end
`ifdef AES_CTRL_TAG_EN
          m_tag = q_tag.pop_front();
          n_chk++;
          if (o_Tag !== m_tag) begin
            n_fail++;
            $display("FAIL sb_tag: got %0d, required %0d", o_Tag, m_tag);
          end
`endif
        end
        out_log.push_back(o_Cipher_Text);
      end
      if (i_Valid && o_Ready) begin
        q_ct.push_back(model(i_Key, i_Plain_Text));
`ifdef AES_CTRL_TAG_EN
        q_tag.push_back(i_Tag);
`endif
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    i_Valid = 1'b0;
    i_Ready = 1'b1;
    i_Key = '0;
    i_Plain_Text = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    q_ct.delete();
    out_log.delete();
`ifdef AES_CTRL_TAG_EN
    q_tag.delete();
`endif
  endtask

  task automatic start_key(input logic [127:0] key, output int k);
    i_Key = key;
    i_Valid = 1'b1;
    @(posedge clk);
    #1;
    i_Valid = 1'b0;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (o_Ready) break;
      @(posedge clk);
      #1;
      k++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] pt, output int cyc);
    logic a;
    i_Plain_Text = pt;
    i_Valid = 1'b1;
    cyc = 0;
    a = 1'b0;
    while (!a && cyc < 200) begin
      @(negedge clk);
      a = o_Ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!a) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got no accept, required accept within 200 cycles");
    end
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((q_ct.size() != 0 || o_Valid) && c < 400) begin
      @(posedge clk);
      #1;
      c++;
    end
    n_chk++;
    if (q_ct.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, required 0", q_ct.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_Valid = 1'b1;
    i_Plain_Text = FIPS_V1_PT;
    #2;
    n_chk += 4;
    if (o_Ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b, required 0", o_Ready); end
    if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", o_Valid); end
    if (o_Busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", o_Busy); end
    if (o_Pipe_Key !== '0) begin n_fail++; $display("FAIL rst_key: got %h, required 0", o_Pipe_Key); end
    n_chk++;
    if (o_Pipe_Plain_Text !== FIPS_V1_PT) begin
      n_fail++;
      $display("FAIL pt_pass: got %h, required %h", o_Pipe_Plain_Text, FIPS_V1_PT);
    end
    do_reset();
  endtask

  task automatic test_vector1();
    int k;
    int c;
    i_Ready = 1'b1;
    start_key(FIPS_V1_KEY, k);
    n_chk += 2;
    if (k != KLAT) begin n_fail++; $display("FAIL key_settle: got %0d, required %0d", k, KLAT); end
    if (o_Pipe_Key !== FIPS_V1_KEY) begin
      n_fail++;
      $display("FAIL pipe_key: got %h, required %h", o_Pipe_Key, FIPS_V1_KEY);
    end
    send(FIPS_V1_PT, c);
    i_Valid = 1'b0;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (o_Valid) break;
      @(posedge clk);
      k++;
    end
    n_chk += 2;
    if (k != LAT) begin n_fail++; $display("FAIL ct_latency: got %0d, required %0d", k, LAT); end
    if (o_Cipher_Text !== FIPS_V1_CT) begin
      n_fail++;
      $display("FAIL v1_ct: got %h, required %h", o_Cipher_Text, FIPS_V1_CT);
    end
    @(posedge clk);
    #1;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int k;
    int c;
    int tot;
    do_reset();
    start_key(FIPS_B_KEY, k);
    tot = 0;
    for (int i = 0; i < 20; i++) begin
      send((i == 0) ? FIPS_B_PT : mkpt(i), c);
      tot += c;
    end
    i_Valid = 1'b0;
    wait_drain();
    n_chk += 3;
    if (tot != 20) begin n_fail++; $display("FAIL b2b_cycles: got %0d, required 20", tot); end
    if (out_log.size() != 20) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d, required 20", out_log.size());
    end else if (out_log[0] !== FIPS_B_CT) begin
      n_fail++;
      $display("FAIL b2b_ct0: got %h, required %h", out_log[0], FIPS_B_CT);
    end
  endtask

  task automatic test_backpressure();
    int k;
    int c;
    int idx;
    logic a;
    do_reset();
    start_key(FIPS_V1_KEY, k);
    i_Ready = 1'b0;
    idx = 0;
    i_Plain_Text = mkpt(100);
    i_Valid = 1'b1;
    repeat (40) begin
      @(negedge clk);
      a = o_Ready;
      @(posedge clk);
      #1;
      if (a) begin
        idx++;
        i_Plain_Text = mkpt(100 + idx);
      end
    end
    n_chk += 3;
    if (idx != DEPTH) begin n_fail++; $display("FAIL bp_accepts: got %0d, required %0d", idx, DEPTH); end
    if (o_Ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b, required 0", o_Ready); end
    if (o_Valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b, required 1", o_Valid); end
    i_Ready = 1'b1;
    for (int j = 0; j < 8; j++) send(mkpt(200 + j), c);
    i_Valid = 1'b0;
    wait_drain();
    n_chk++;
    if (out_log.size() != DEPTH + 8) begin
      n_fail++;
      $display("FAIL bp_count: got %0d, required %0d", out_log.size(), DEPTH + 8);
    end
  endtask

  task automatic test_key_change();
    int k;
    int c;
    int rdy;
    do_reset();
    start_key(FIPS_V1_KEY, k);
    send(FIPS_V1_PT, c);
    for (int i = 1; i < 5; i++) send(mkpt(300 + i), c);
    i_Key = FIPS_B_KEY;
    i_Plain_Text = FIPS_B_PT;
    rdy = 0;
    c = 0;
    while (c < 100) begin
      @(negedge clk);
      if (o_Pipe_Key == FIPS_B_KEY) break;
      if (o_Ready) rdy++;
      @(posedge clk);
      #1;
      c++;
    end
    n_chk += 3;
    if (o_Pipe_Key !== FIPS_B_KEY) begin
      n_fail++;
      $display("FAIL kc_switch: got %h, required %h", o_Pipe_Key, FIPS_B_KEY);
    end
    if (rdy != 0) begin n_fail++; $display("FAIL kc_drain_ready: got %0d, required 0", rdy); end
    if (out_log.size() != 5) begin
      n_fail++;
      $display("FAIL kc_a_done: got %0d, required 5", out_log.size());
    end
    k = 0;
    while (!o_Ready && k < 50) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    n_chk++;
    if (k != KLAT) begin n_fail++; $display("FAIL kc_settle: got %0d, required %0d", k, KLAT); end
    @(posedge clk);
    #1;
    i_Valid = 1'b0;
    wait_drain();
    n_chk++;
    if (out_log.size() != 6) begin
      n_fail++;
      $display("FAIL kc_count: got %0d, required 6", out_log.size());
    end else if (out_log[5] !== FIPS_B_CT) begin
      n_fail++;
      $display("FAIL kc_b_ct: got %h, required %h", out_log[5], FIPS_B_CT);
    end
  endtask

  task automatic test_async_reset();
    int k;
    int c;
    int vc;
    do_reset();
    i_Ready = 1'b0;
    start_key(FIPS_V1_KEY, k);
    for (int i = 0; i < 5; i++) send(mkpt(400 + i), c);
    i_Valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_chk += 2;
    if (o_Valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid: got %b, required 1", o_Valid); end
    if (o_Busy !== 1'b1) begin n_fail++; $display("FAIL ar_pre_busy: got %b, required 1", o_Busy); end
    rst_n = 1'b0;
    #1;
    n_chk += 3;
    if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b, required 0", o_Valid); end
    if (o_Busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy: got %b, required 0", o_Busy); end
    if (o_Ready !== 1'b0) begin n_fail++; $display("FAIL ar_ready: got %b, required 0", o_Ready); end
    q_ct.delete();
    out_log.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    i_Ready = 1'b1;
    vc = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_Valid) vc++;
    end
    n_chk++;
    if (vc != 0) begin n_fail++; $display("FAIL ar_stale: got %0d valid cycles, required 0", vc); end
    @(posedge clk);
    #1;
    test_vector1();
  endtask

`ifdef AES_CTRL_TAG_EN
  task automatic test_tag();
    int k;
    int c;
    do_reset();
    start_key(FIPS_B_KEY, k);
    fork
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          i_Ready = 1'($urandom_range(0, 1));
        end
        i_Ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 10; i++) begin
      i_Tag = TW'(i);
      send(mkpt(500 + i), c);
    end
    i_Valid = 1'b0;
    wait_drain();
    n_chk++;
    if (out_log.size() != 10) begin
      n_fail++;
      $display("FAIL tag_count: got %0d, required 10", out_log.size());
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vector1();
    test_back_to_back();
    test_backpressure();
    test_key_change();
    test_async_reset();
`ifdef AES_CTRL_TAG_EN
    test_tag();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
